switch_debouncer: RTL and testbench
===================================

Name: switch_debouncer

Overview:
- Sits between the board slide switches (SW) and their consumers: the Nios PIO switch input and the direct LED path.
- Per channel: 2-flop synchroniser, then a stability counter, then a debounced level plus one-cycle rise/fall pulses.
- Removes metastability and contact bounce so software and LED logic see one clean transition per physical flip.

Parameters:
- N_SW, 2, number of independent switch channels.
- DEBOUNCE_CYCLES, 500000, clock cycles an input must be stable before it is accepted (10 ms at 50 MHz); legal range >= 1.
- RESET_VAL, 1'b0, value loaded into the synchroniser flops and the debounced level on reset (same value for all channels).

Ports:
- MAX10_CLK1_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- sw_raw  in  N_SW  raw asynchronous switch pins.
- sw_db  out  N_SW  debounced, synchronous switch level.
- sw_rise  out  N_SW  one-cycle pulse when sw_db goes 0->1.
- sw_fall  out  N_SW  one-cycle pulse when sw_db goes 1->0.
- sw_toggle_cnt  out  8*N_SW  per-channel accepted-transition count, channel i at bits [8i+7:8i]; see Optional Feature.

Behaviour:
- Reset (async assert, sync-safe release):
  - sync flops and sw_db = RESET_VAL.
  - counters, sw_rise, sw_fall and sw_toggle_cnt = 0.
  - No edge pulse is generated on reset release.
- Synchroniser: sw_raw[i] -> s1 -> s2. Only s2 is used downstream.
- Counter: width $clog2(DEBOUNCE_CYCLES+1). Per channel, each cycle:
  - s2 == sw_db: counter cleared to 0.
  - s2 != sw_db and counter < DEBOUNCE_CYCLES-1: counter increments.
  - s2 != sw_db and counter == DEBOUNCE_CYCLES-1: on the next edge, sw_db <= s2, counter <= 0, and the matching sw_rise/sw_fall pulses high for exactly that one cycle.
- Per-channel FSM, 2 states: STABLE (counter idle) and PENDING (counter running). The counter-nonzero flag is the state; no extra state register.
- Latency: a clean step on sw_raw appears on sw_db exactly 2 + DEBOUNCE_CYCLES edges later. Pulses are coincident with the sw_db change and registered.
- Bounce: any return of s2 to sw_db while PENDING clears the counter. A glitch shorter than DEBOUNCE_CYCLES never reaches sw_db.
- Minimum spacing: two accepted transitions on one channel are at least DEBOUNCE_CYCLES cycles apart. rise and fall are never high together.
- Channels are fully independent. Simultaneous events on multiple channels produce simultaneous pulses.
- DEBOUNCE_CYCLES == 1: sw_db follows s2 with one cycle of delay.
- Reset mid-PENDING: the pending transition is discarded and the channel returns to RESET_VAL.
- No combinational path from input to output.

Optional Feature:
- Macro: SWITCH_DEBOUNCER_TOGGLE_CNT_EN.
- Defined: each channel keeps an 8-bit counter, incremented on every accepted transition (rise or fall). It wraps 255 -> 0 and is cleared only by reset. It is visible on sw_toggle_cnt the same cycle the pulse is high (registered, updates with sw_db).
- Undefined: no counter logic is built and sw_toggle_cnt is tied to 0. The port list is identical in both builds.

Decomposition:
- Package switch_debouncer_pkg:
  - SW_CLK_HZ = 50_000_000.
  - function ms_to_cycles(ms).
  - typedef logic [7:0] toggle_cnt_t.
- Sub-module sw_debounce_ch: one channel (synchroniser, counter, level, pulses, optional toggle count). The top instantiates it N_SW times in a generate loop.

Test Plan (DEBOUNCE_CYCLES=4, N_SW=2, RESET_VAL=0):
1. Reset held, then released with sw_raw=2'b00 -> sw_db=00, no pulses, sw_toggle_cnt=0.
2. sw_raw[0] 0->1 at edge k, held -> sw_db[0]=1 and sw_rise[0]=1 for one cycle at edge k+6; sw_db[1] stays 0.
3. sw_raw[1] bounces 1,0,1,0 at 1-cycle spacing, then settles 1 -> exactly one sw_rise[1], 6 cycles after the final settle; no sw_fall[1].
4. A 3-cycle high glitch on sw_raw[0] -> sw_db[0] never changes, no pulses.
5. Both channels step 1->0 on the same edge from sw_db=11 -> both sw_fall bits high on the same cycle, 6 edges later.
6. Reset asserted mid-PENDING (counter=2) -> sw_db=00 immediately; after release, no pulse. With SWITCH_DEBOUNCER_TOGGLE_CNT_EN: 256 accepted toggles on ch0 -> count wraps to 0.

Source files
------------

// File: rtl/switch_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switch_debouncer_pkg
// Description : Shared constants, types and helpers for the switch debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package switch_debouncer_pkg;

    localparam int unsigned SW_CLK_HZ = 50_000_000;
    localparam int          TOGGLE_W  = 8;

    typedef logic [TOGGLE_W-1:0] toggle_cnt_t;

    // The state is never stored: it is decoded from the stability counter.
    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } ch_state_t;

    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (SW_CLK_HZ / 1000) * ms;
    endfunction

endpackage : switch_debouncer_pkg
`default_nettype wire

// File: rtl/sw_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce_ch
// Description : One switch channel: 2-flop synchroniser, stability counter,
//               debounced level, rise/fall pulses and an optional transition
//               count (built when SWITCH_DEBOUNCER_TOGGLE_CNT_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce_ch
    import switch_debouncer_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 500_000,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                raw,
    output logic                db,
    output logic                rise,
    output logic                fall,
    output logic [TOGGLE_W-1:0] toggle_cnt
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    ch_state_t        state;
    logic             differ;
    logic             accept;

    assign state  = (cnt == '0) ? ST_STABLE : ST_PENDING;
    assign differ = s2 ^ db;
    // With DEBOUNCE_CYCLES == 1 the last count is 0, so acceptance happens
    // straight from STABLE and the level simply trails s2 by one cycle.
    assign accept = differ && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= RESET_VAL;
            s2   <= RESET_VAL;
            db   <= RESET_VAL;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            if (accept) begin
                db   <= s2;
                cnt  <= '0;
                rise <= s2;
                fall <= ~s2;
            end else begin
                case (state)
                    ST_STABLE: begin
                        if (differ) begin
                            cnt <= CNT_ONE;
                        end
                    end
                    ST_PENDING: begin
                        if (differ) begin
                            cnt <= cnt + CNT_ONE;
                        end else begin
                            cnt <= '0;
                        end
                    end
                    default: begin
                        cnt <= '0;
                    end
                endcase
            end
        end
    end

`ifdef SWITCH_DEBOUNCER_TOGGLE_CNT_EN
    toggle_cnt_t tcnt;

    // Wraps naturally at 255 -> 0; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (accept) begin
            tcnt <= tcnt + toggle_cnt_t'(1);
        end
    end

    assign toggle_cnt = tcnt;
`else
    assign toggle_cnt = '0;
`endif

endmodule : sw_debounce_ch
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : switch_debouncer
// Description : N_SW independent switch debouncers for the board slide
//               switches. Optional per-channel transition counters are built
//               when SWITCH_DEBOUNCER_TOGGLE_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int   N_SW            = 2,
    parameter int   DEBOUNCE_CYCLES = 500_000,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic                     MAX10_CLK1_50,
    input  logic                     reset,
    input  logic [N_SW-1:0]          sw_raw,
    output logic [N_SW-1:0]          sw_db,
    output logic [N_SW-1:0]          sw_rise,
    output logic [N_SW-1:0]          sw_fall,
    output logic [TOGGLE_W*N_SW-1:0] sw_toggle_cnt
);

    generate
        for (genvar i = 0; i < N_SW; i++) begin : g_ch
            sw_debounce_ch #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_VAL       (RESET_VAL)
            ) u_ch (
                .clk        (MAX10_CLK1_50),
                .rst        (reset),
                .raw        (sw_raw[i]),
                .db         (sw_db[i]),
                .rise       (sw_rise[i]),
                .fall       (sw_fall[i]),
                .toggle_cnt (sw_toggle_cnt[TOGGLE_W*i +: TOGGLE_W])
            );
        end
    endgenerate

endmodule : switch_debouncer
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_debouncer
// Description : Directed self-checking bench, DEBOUNCE_CYCLES=4, N_SW=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;

`ifdef SWITCH_DEBOUNCER_TOGGLE_CNT_EN
    localparam bit TCNT_EN = 1'b1;
`else
    localparam bit TCNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  sw_raw = 2'b00;
    logic [1:0]  sw_db;
    logic [1:0]  sw_rise;
    logic [1:0]  sw_fall;
    logic [15:0] sw_toggle_cnt;

    int total = 0;
    int bad   = 0;
    int rc0 = 0, rc1 = 0, fc0 = 0, fc1 = 0, both = 0;

    switch_debouncer #(
        .N_SW            (2),
        .DEBOUNCE_CYCLES (4),
        .RESET_VAL       (1'b0)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .reset         (rst),
        .sw_raw        (sw_raw),
        .sw_db         (sw_db),
        .sw_rise       (sw_rise),
        .sw_fall       (sw_fall),
        .sw_toggle_cnt (sw_toggle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (sw_rise[0]) rc0++;
            if (sw_rise[1]) rc1++;
            if (sw_fall[0]) fc0++;
            if (sw_fall[1]) fc1++;
            if (|(sw_rise & sw_fall)) both++;
        end
    endtask

    task automatic clr_counts();
        rc0 = 0; rc1 = 0; fc0 = 0; fc1 = 0;
    endtask

    function automatic logic [15:0] tc(input int c1, input int c0);
        return TCNT_EN ? {8'(c1), 8'(c0)} : 16'h0000;
    endfunction

    initial begin
        // 1: reset, then release
        step(3);
        chk("rst_db", 32'(sw_db), 32'h0);
        chk("rst_pulses", 32'({sw_rise, sw_fall}), 32'h0);
        chk("rst_tcnt", 32'(sw_toggle_cnt), 32'h0);
        rst = 1'b0;
        clr_counts();
        step(8);
        chk("rel_db", 32'(sw_db), 32'h0);
        chk("rel_no_pulse", 32'(rc0 + rc1 + fc0 + fc1), 32'd0);

        // 2: clean rise on ch0, visible 6 edges later
        sw_raw = 2'b01;
        step(5);
        chk("s2_db_before", 32'(sw_db), 32'h0);
        step(1);
        chk("s2_db_after", 32'(sw_db), 32'h1);
        chk("s2_rise", 32'(sw_rise), 32'h1);
        chk("s2_fall", 32'(sw_fall), 32'h0);
        chk("s2_tcnt", 32'(sw_toggle_cnt), 32'(tc(0, 1)));
        step(1);
        chk("s2_rise_1cyc", 32'(sw_rise), 32'h0);

        // 3: bounce on ch1, one rise 6 edges after final settle
        clr_counts();
        sw_raw[1] = 1'b1; step(1);
        sw_raw[1] = 1'b0; step(1);
        sw_raw[1] = 1'b1; step(1);
        sw_raw[1] = 1'b0; step(1);
        sw_raw[1] = 1'b1;
        step(5);
        chk("s3_db_before", 32'(sw_db), 32'h1);
        chk("s3_no_early_rise", 32'(rc1), 32'd0);
        step(1);
        chk("s3_db_after", 32'(sw_db), 32'h3);
        chk("s3_rise", 32'(sw_rise), 32'h2);
        step(3);
        chk("s3_one_rise", 32'(rc1), 32'd1);
        chk("s3_no_fall", 32'(fc1), 32'd0);
        chk("s3_tcnt", 32'(sw_toggle_cnt), 32'(tc(1, 1)));

        // 3-cycle low glitch on ch0 is filtered
        clr_counts();
        sw_raw[0] = 1'b0; step(3);
        sw_raw[0] = 1'b1; step(10);
        chk("lglitch_db", 32'(sw_db), 32'h3);
        chk("lglitch_pulses", 32'(rc0 + fc0), 32'd0);

        // 5: both fall on the same edge
        clr_counts();
        sw_raw = 2'b00;
        step(5);
        chk("s5_db_before", 32'(sw_db), 32'h3);
        step(1);
        chk("s5_db_after", 32'(sw_db), 32'h0);
        chk("s5_fall", 32'(sw_fall), 32'h3);
        chk("s5_rise", 32'(sw_rise), 32'h0);
        chk("s5_tcnt", 32'(sw_toggle_cnt), 32'(tc(2, 2)));

        // 4: 3-cycle high glitch on ch0 is filtered
        step(2);
        clr_counts();
        sw_raw[0] = 1'b1; step(3);
        sw_raw[0] = 1'b0; step(10);
        chk("hglitch_db", 32'(sw_db), 32'h0);
        chk("hglitch_pulses", 32'(rc0 + fc0), 32'd0);

        // 6: reset in the middle of a pending fall
        sw_raw = 2'b11;
        step(6);
        chk("s6_db_up", 32'(sw_db), 32'h3);
        chk("s6_tcnt_up", 32'(sw_toggle_cnt), 32'(tc(3, 3)));
        step(2);
        sw_raw = 2'b00;
        step(4);
        chk("s6_db_pending", 32'(sw_db), 32'h3);
        rst = 1'b1;
        #1;
        chk("s6_db_async", 32'(sw_db), 32'h0);
        chk("s6_tcnt_async", 32'(sw_toggle_cnt), 32'h0);
        step(2);
        rst = 1'b0;
        clr_counts();
        step(10);
        chk("s6_db_release", 32'(sw_db), 32'h0);
        chk("s6_no_pulse", 32'(rc0 + rc1 + fc0 + fc1), 32'd0);

        // 256 accepted toggles on ch0
        clr_counts();
        for (int k = 0; k < 256; k++) begin
            sw_raw[0] = ~sw_raw[0];
            step(6);
            if (k == 254) chk("wrap_255", 32'(sw_toggle_cnt), 32'(tc(0, 255)));
        end
        chk("wrap_0", 32'(sw_toggle_cnt), 32'(tc(0, 0)));
        chk("wrap_rises", 32'(rc0), 32'd128);
        chk("wrap_falls", 32'(fc0), 32'd128);
        chk("wrap_db", 32'(sw_db), 32'h0);
        chk("never_both", 32'(both), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_switch_debouncer
`default_nettype wire
